quad_step_decoder: RTL



---
 rtl/quad_pkg.sv | 37 +++
 rtl/quad_phase_filter.sv | 47 ++++
 rtl/quad_step_decoder.sv | 105 ++++++++++
 3 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature step decoder: phase codes, FSM state
// encoding and the classifier that turns a {A,B} code change into a step kind.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;

  typedef enum logic [1:0] {
    TR_NONE,
    TR_UP,
    TR_DOWN,
    TR_ILLEGAL
  } trans_t;

  // Any single-bit change is legal; it is "up" only if it follows 00->01->11->10->00.
  function automatic trans_t classify(input logic [1:0] prevAb, input logic [1:0] curAb);
    trans_t t;
    t = TR_NONE;
    if ((prevAb ^ curAb) == 2'b11) begin
      t = TR_ILLEGAL;
    end else if (prevAb != curAb) begin
      case (prevAb)
        PH_00:   t = (curAb == PH_01) ? TR_UP : TR_DOWN;
        PH_01:   t = (curAb == PH_11) ? TR_UP : TR_DOWN;
        PH_11:   t = (curAb == PH_10) ? TR_UP : TR_DOWN;
        default: t = (curAb == PH_00) ? TR_UP : TR_DOWN;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/quad_phase_filter.sv
// Synchronizer chain plus glitch filter for one asynchronous quadrature phase.
// The filtered output only follows the input after FILTER_CYCLES+1 disagreeing edges.
module quad_phase_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_phase,
  output logic o_filt
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign o_filt   = r_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_phase};
    end
  end

  // Counter sits at FILTER_CYCLES for one edge before the filtered value flips.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_filt <= 1'b0;
    end else if (w_synced == r_filt) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_MAX) begin
      r_filt <= w_synced;
      r_cnt  <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: filtered A/B phases drive a two-state tracker that emits
// step/dir pulses, keeps a wrapping position count and flags illegal jumps.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic             step,
  output logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             err,
  output logic             err_flag
);

  logic             w_filtA;
  logic             w_filtB;
  logic [1:0]       w_curAb;
  trans_t           w_trans;
  logic [0:0]       r_state;
  logic [1:0]       r_prevAb;
  logic             r_step;
  logic             r_dir;
  logic             r_err;
  logic             r_errFlag;
  logic [CNT_W-1:0] r_count;

  quad_phase_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filtA (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_phase(enc_a),
    .o_filt (w_filtA)
  );

  quad_phase_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_filtB (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_phase(enc_b),
    .o_filt (w_filtB)
  );

  assign w_curAb = {w_filtA, w_filtB};
  assign w_trans = classify(r_prevAb, w_curAb);

  // INIT only captures the resting position; clr is applied last so it overrides count/flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_prevAb  <= PH_00;
      r_step    <= 1'b0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_errFlag <= 1'b0;
      r_count   <= '0;
    end else begin
      r_step   <= 1'b0;
      r_err    <= 1'b0;
      r_prevAb <= w_curAb;
      if (r_state == ST_INIT) begin
        r_state <= ST_TRACK;
      end else begin
        case (w_trans)
          TR_UP: begin
            r_step  <= 1'b1;
            r_dir   <= 1'b1;
            r_count <= r_count + CNT_W'(1);
          end
          TR_DOWN: begin
            r_step  <= 1'b1;
            r_dir   <= 1'b0;
            r_count <= r_count - CNT_W'(1);
          end
          TR_ILLEGAL: begin
            r_err     <= 1'b1;
            r_errFlag <= 1'b1;
          end
          default: ;
        endcase
      end
      if (clr) begin
        r_count   <= '0;
        r_errFlag <= 1'b0;
      end
    end
  end

  assign step     = r_step;
  assign dir      = r_dir;
  assign count    = r_count;
  assign err      = r_err;
  assign err_flag = r_errFlag;

endmodule
